// File: rtl/stack_alu_unit.sv
// -----------------------------------------------------------------------------
// stack_alu_unit
// Datapath storage and arithmetic core for the brus16 stack CPU.
//   - data stack   : 2**STACK_WIDTH x 16 bit, two combinational read ports,
//                    one synchronous write port
//   - return stack : 2**RSTACK_WIDTH x CODE_WIDTH bit, one combinational read
//                    port, one synchronous write port
//   - ALU          : purely combinational 16-bit, 5-bit opcode
// The CPU control logic owns sp/rsp and drives every address; no pointer
// state lives here.
//
// Ports:
//   clk                          rising-edge clock for all writes
//   reset                        asynchronous, active-low; clears both stacks
//   ds_rd_addr0 / ds_rd_data0    data stack read port 0 (top of stack)
//   ds_rd_addr1 / ds_rd_data1    data stack read port 1 (top-1)
//   ds_we, ds_wr_addr, ds_wr_data       data stack write port
//   rs_rd_addr / rs_rd_data      return stack read port
//   rs_we, rs_wr_addr, rs_wr_data       return stack write port
//   alu_op, alu_a, alu_b / alu_out      combinational ALU
// -----------------------------------------------------------------------------
module stack_alu_unit #(
    parameter int STACK_WIDTH  = 4,
    parameter int RSTACK_WIDTH = 4,
    parameter int CODE_WIDTH   = 13
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [STACK_WIDTH-1:0]  ds_rd_addr0,
    output logic [15:0]             ds_rd_data0,
    input  logic [STACK_WIDTH-1:0]  ds_rd_addr1,
    output logic [15:0]             ds_rd_data1,
    input  logic                    ds_we,
    input  logic [STACK_WIDTH-1:0]  ds_wr_addr,
    input  logic [15:0]             ds_wr_data,
    input  logic [RSTACK_WIDTH-1:0] rs_rd_addr,
    output logic [CODE_WIDTH-1:0]   rs_rd_data,
    input  logic                    rs_we,
    input  logic [RSTACK_WIDTH-1:0] rs_wr_addr,
    input  logic [CODE_WIDTH-1:0]   rs_wr_data,
    input  logic [4:0]              alu_op,
    input  logic [15:0]             alu_a,
    input  logic [15:0]             alu_b,
    output logic [15:0]             alu_out
);

    localparam int DS_DEPTH = 2 ** STACK_WIDTH;
    localparam int RS_DEPTH = 2 ** RSTACK_WIDTH;

    // Storage is built from flops rather than RAM: the whole array must clear
    // asynchronously, which no block RAM primitive supports.
    logic [15:0]           r_ds_mem [DS_DEPTH];
    logic [CODE_WIDTH-1:0] r_rs_mem [RS_DEPTH];

    // One register per entry so each carries its own async clear and write
    // decode; reset takes priority over a coincident write.
    for (genvar gi = 0; gi < DS_DEPTH; gi++) begin : g_ds_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_ds_mem[gi] <= '0;
            end else if (ds_we && (ds_wr_addr == STACK_WIDTH'(gi))) begin
                r_ds_mem[gi] <= ds_wr_data;
            end
        end
    end

    for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_rs_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rs_mem[gi] <= '0;
            end else if (rs_we && (rs_wr_addr == RSTACK_WIDTH'(gi))) begin
                r_rs_mem[gi] <= rs_wr_data;
            end
        end
    end

    // Zero-latency reads with no write bypass: a same-address write only
    // becomes visible after the edge that commits it.
    assign ds_rd_data0 = r_ds_mem[ds_rd_addr0];
    assign ds_rd_data1 = r_ds_mem[ds_rd_addr1];
    assign rs_rd_data  = r_rs_mem[rs_rd_addr];

    // ---------------------------------------------------------------- ALU
    logic [3:0]  w_shamt;
    logic [15:0] w_alu_out;

    assign w_shamt = alu_b[3:0];    // upper shift bits deliberately ignored

    always_comb begin
        w_alu_out = 16'd0;
        case (alu_op)
            5'd0:  w_alu_out = alu_a + alu_b;
            5'd1:  w_alu_out = alu_a - alu_b;
            5'd2:  w_alu_out = alu_a * alu_b;   // 16-bit context keeps low half
            5'd3:  w_alu_out = alu_a & alu_b;
            5'd4:  w_alu_out = alu_a | alu_b;
            5'd5:  w_alu_out = alu_a ^ alu_b;
            5'd6:  w_alu_out = alu_a << w_shamt;
            5'd7:  w_alu_out = alu_a >> w_shamt;
            5'd8:  w_alu_out = $unsigned($signed(alu_a) >>> w_shamt);
            5'd9:  w_alu_out = {15'd0, alu_a == alu_b};
            5'd10: w_alu_out = {15'd0, alu_a != alu_b};
            5'd11: w_alu_out = {15'd0, $signed(alu_a) <  $signed(alu_b)};
            5'd12: w_alu_out = {15'd0, $signed(alu_a) <= $signed(alu_b)};
            5'd13: w_alu_out = {15'd0, $signed(alu_a) >  $signed(alu_b)};
            5'd14: w_alu_out = {15'd0, $signed(alu_a) >= $signed(alu_b)};
            5'd15: w_alu_out = {15'd0, alu_a < alu_b};
            default: w_alu_out = 16'd0;         // opcodes 16..31 reserved
        endcase
    end

    assign alu_out = w_alu_out;

endmodule

// File: tb/tb_stack_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_alu_unit
// Directed bench for stack_alu_unit: hand-written sequences for reset, stack
// write/read, read-during-write and pointer wrap, plus a table of ALU vectors.
// -----------------------------------------------------------------------------
module tb_stack_alu_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  ds_rd_addr0, ds_rd_addr1, ds_wr_addr;
    logic [15:0] ds_rd_data0, ds_rd_data1, ds_wr_data;
    logic        ds_we;
    logic [3:0]  rs_rd_addr, rs_wr_addr;
    logic [12:0] rs_rd_data, rs_wr_data;
    logic        rs_we;
    logic [4:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_out;

    int n_cmp  = 0;
    int n_fail = 0;

    stack_alu_unit #(
        .STACK_WIDTH (4),
        .RSTACK_WIDTH(4),
        .CODE_WIDTH  (13)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ds_rd_addr0(ds_rd_addr0),
        .ds_rd_data0(ds_rd_data0),
        .ds_rd_addr1(ds_rd_addr1),
        .ds_rd_data1(ds_rd_data1),
        .ds_we      (ds_we),
        .ds_wr_addr (ds_wr_addr),
        .ds_wr_data (ds_wr_data),
        .rs_rd_addr (rs_rd_addr),
        .rs_rd_data (rs_rd_data),
        .rs_we      (rs_we),
        .rs_wr_addr (rs_wr_addr),
        .rs_wr_data (rs_wr_data),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } alu_vec_t;

    alu_vec_t vec [27];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive a write on the falling edge so it is committed by the next rising edge.
    task automatic ds_write(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        ds_we = 1'b1; ds_wr_addr = addr; ds_wr_data = data;
        @(negedge clk);
        ds_we = 1'b0;
    endtask

    task automatic rs_write(input logic [3:0] addr, input logic [12:0] data);
        @(negedge clk);
        rs_we = 1'b1; rs_wr_addr = addr; rs_wr_data = data;
        @(negedge clk);
        rs_we = 1'b0;
    endtask

    initial begin
        // ALU vectors: a=-1, b=1 across all defined opcodes
        vec[0]  = '{5'd0,  16'hFFFF, 16'h0001, 16'h0000};
        vec[1]  = '{5'd1,  16'hFFFF, 16'h0001, 16'hFFFE};
        vec[2]  = '{5'd2,  16'hFFFF, 16'h0001, 16'hFFFF};
        vec[3]  = '{5'd3,  16'hFFFF, 16'h0001, 16'h0001};
        vec[4]  = '{5'd4,  16'hFFFF, 16'h0001, 16'hFFFF};
        vec[5]  = '{5'd5,  16'hFFFF, 16'h0001, 16'hFFFE};
        vec[6]  = '{5'd6,  16'hFFFF, 16'h0001, 16'hFFFE};
        vec[7]  = '{5'd7,  16'hFFFF, 16'h0001, 16'h7FFF};
        vec[8]  = '{5'd8,  16'hFFFF, 16'h0001, 16'hFFFF};
        vec[9]  = '{5'd9,  16'hFFFF, 16'h0001, 16'h0000};
        vec[10] = '{5'd10, 16'hFFFF, 16'h0001, 16'h0001};
        vec[11] = '{5'd11, 16'hFFFF, 16'h0001, 16'h0001};
        vec[12] = '{5'd12, 16'hFFFF, 16'h0001, 16'h0001};
        vec[13] = '{5'd13, 16'hFFFF, 16'h0001, 16'h0000};
        vec[14] = '{5'd14, 16'hFFFF, 16'h0001, 16'h0000};
        vec[15] = '{5'd15, 16'hFFFF, 16'h0001, 16'h0000};
        // shift amount from b[3:0] only
        vec[16] = '{5'd6,  16'h0003, 16'h0013, 16'h0018};
        vec[17] = '{5'd7,  16'h8000, 16'h0014, 16'h0800};
        vec[18] = '{5'd8,  16'h8000, 16'h0014, 16'hF800};
        // equal operands
        vec[19] = '{5'd9,  16'h0007, 16'h0007, 16'h0001};
        vec[20] = '{5'd12, 16'h0007, 16'h0007, 16'h0001};
        vec[21] = '{5'd14, 16'h0007, 16'h0007, 16'h0001};
        vec[22] = '{5'd11, 16'h0007, 16'h0007, 16'h0000};
        // reversed operands, reserved opcode, wider multiply
        vec[23] = '{5'd15, 16'h0001, 16'hFFFF, 16'h0001};
        vec[24] = '{5'd13, 16'h0001, 16'hFFFF, 16'h0001};
        vec[25] = '{5'd20, 16'hFFFF, 16'h0001, 16'h0000};
        vec[26] = '{5'd2,  16'h0123, 16'h0100, 16'h2300};

        reset = 1'b0;
        ds_rd_addr0 = 4'd5; ds_rd_addr1 = 4'd9; ds_we = 1'b0; ds_wr_addr = '0; ds_wr_data = '0;
        rs_rd_addr = 4'd2; rs_we = 1'b0; rs_wr_addr = '0; rs_wr_data = '0;
        alu_op = '0; alu_a = '0; alu_b = '0;

        // --- reset state
        #1;
        check("reset_ds0", ds_rd_data0, 16'h0000);
        check("reset_ds1", ds_rd_data1, 16'h0000);
        check("reset_rs",  {3'b0, rs_rd_data}, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // --- fill both stacks with distinct patterns
        for (int i = 0; i < 16; i++) ds_write(4'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 16; i++) rs_write(4'(i), 13'(i + 100));

        // --- data stack write/read, both ports same cycle
        ds_write(4'd3, 16'hBEEF);
        ds_write(4'd2, 16'h1234);
        ds_rd_addr0 = 4'd3; ds_rd_addr1 = 4'd2;
        #1;
        check("ds_rd0_addr3", ds_rd_data0, 16'hBEEF);
        check("ds_rd1_addr2", ds_rd_data1, 16'h1234);
        ds_rd_addr1 = 4'd3;
        #1;
        check("ds_same_addr", ds_rd_data1, 16'hBEEF);

        // --- read-during-write at addr 15: old before edge, new after
        @(negedge clk);
        ds_rd_addr0 = 4'd15;
        ds_we = 1'b1; ds_wr_addr = 4'd15; ds_wr_data = 16'h00AA;
        #1;
        check("rdw_before", ds_rd_data0, 16'h100F);
        @(posedge clk);
        #1;
        check("rdw_after", ds_rd_data0, 16'h00AA);
        @(negedge clk);
        ds_we = 1'b0;

        // --- wrap: sp=15, sp+1 truncates to 0
        ds_write(4'd0, 16'h0055);
        ds_rd_addr0 = 4'(ds_rd_addr0 + 4'd1);
        ds_rd_addr1 = 4'd14;
        #1;
        check("wrap_addr0", ds_rd_data0, 16'h0055);
        check("wrap_no_corrupt14", ds_rd_data1, 16'h100E);
        ds_rd_addr1 = 4'd15;
        #1;
        check("wrap_keep15", ds_rd_data1, 16'h00AA);

        // --- return stack, then write enable low must not disturb it
        rs_write(4'd0, 13'h1FFF);
        rs_write(4'd1, 13'h0005);
        @(negedge clk);
        rs_we = 1'b0; rs_wr_addr = 4'd0; rs_wr_data = 13'h0ABC;
        @(negedge clk);
        rs_wr_addr = 4'd1;
        @(negedge clk);
        rs_rd_addr = 4'd0;
        #1;
        check("rs_addr0", {3'b0, rs_rd_data}, 16'h1FFF);
        rs_rd_addr = 4'd1;
        #1;
        check("rs_addr1", {3'b0, rs_rd_data}, 16'h0005);
        rs_rd_addr = 4'd7;
        #1;
        check("rs_addr7", {3'b0, rs_rd_data}, 16'd107);

        // --- mid-run reset: clears immediately, before any clock edge
        @(posedge clk);
        #1;
        reset = 1'b0;
        ds_rd_addr0 = 4'd3; ds_rd_addr1 = 4'd15; rs_rd_addr = 4'd0;
        #1;
        check("midrst_ds0_imm", ds_rd_data0, 16'h0000);
        check("midrst_ds1_imm", ds_rd_data1, 16'h0000);
        check("midrst_rs_imm",  {3'b0, rs_rd_data}, 16'h0000);
        // sweep every address while reset stays low
        for (int i = 0; i < 16; i++) begin
            ds_rd_addr0 = 4'(i); ds_rd_addr1 = 4'(15 - i); rs_rd_addr = 4'(i);
            #1;
            check($sformatf("midrst_sweep%0d", i),
                  ds_rd_data0 | ds_rd_data1 | {3'b0, rs_rd_data}, 16'h0000);
        end
        // writes attempted during reset are dropped
        @(negedge clk);
        ds_we = 1'b1; ds_wr_addr = 4'd6; ds_wr_data = 16'hDEAD;
        rs_we = 1'b1; rs_wr_addr = 4'd6; rs_wr_data = 13'h0DAD;
        @(negedge clk);
        ds_we = 1'b0; rs_we = 1'b0;
        reset = 1'b1;
        ds_rd_addr0 = 4'd6; rs_rd_addr = 4'd6;
        #1;
        check("rst_write_ds_ignored", ds_rd_data0, 16'h0000);
        check("rst_write_rs_ignored", {3'b0, rs_rd_data}, 16'h0000);
        // storage works again after release
        ds_write(4'd6, 16'hC0DE);
        #1;
        check("post_rst_write", ds_rd_data0, 16'hC0DE);

        // --- ALU table
        for (int i = 0; i < 27; i++) begin
            alu_op = vec[i].op; alu_a = vec[i].a; alu_b = vec[i].b;
            #1;
            check($sformatf("alu[%0d] op%0d a=%h b=%h", i, vec[i].op, vec[i].a, vec[i].b),
                  alu_out, vec[i].exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
